// File: rtl/fir_decim_stream_pkg.sv
// Shared DSP package: default sample/accumulator sizing and the shift clamp
// used by both the FIR filter and its decimating stream stage.
package fir_decim_stream_pkg;

  localparam int DSP_DATA_WIDTH = 16;
  localparam int DSP_MAX_SHIFT  = 10;

  // Limit a requested log2 rate to the largest rate the accumulator can hold.
  function automatic logic [3:0] clamp_shift(input logic [3:0] req_shift, input int max_shift);
    logic [3:0] res;
    if (int'(req_shift) > max_shift) begin
      res = 4'(max_shift);
    end else begin
      res = req_shift;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_decim_stream_chk.sv
// Structural invariants between the FIFO status flags and the stream output.
module fir_decim_stream_chk #(
  parameter int LW = 5
) (
  input logic          clk,
  input logic          rst,
  input logic          empty,
  input logic          m_tvalid,
  input logic [LW-1:0] level
);

  a_empty_matches_level: assert property (@(posedge clk) disable iff (rst)
    empty == (level == {LW{1'b0}}));

  a_valid_not_empty: assert property (@(posedge clk) disable iff (rst)
    m_tvalid |-> !empty);

endmodule

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with a registered head stage:
// a word written into an empty FIFO becomes visible one clock after the write.
module sync_fifo_fwft #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  input  logic                       rd_ready,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [LW-1:0] CNT_ONE = LW'(1);
  localparam logic [LW-1:0] CNT_MAX = LW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    rd_ptr_n_s;
  logic [LW-1:0]    count_r;
  logic [LW-1:0]    count_n_s;
  logic [LW-1:0]    held_s;
  logic             valid_r;
  logic [WIDTH-1:0] data_r;
  logic             full_s;
  logic             pop_s;
  logic             push_s;

  assign full_s = (count_r == CNT_MAX);
  assign pop_s  = valid_r & rd_ready;
  assign push_s = wr_en & (~full_s | pop_s);

  // Next read pointer, next occupancy, and words that existed before this edge and survive it.
  always_comb begin
    rd_ptr_n_s = rd_ptr_r;
    held_s     = count_r;
    count_n_s  = count_r;
    if (pop_s) begin
      rd_ptr_n_s = rd_ptr_r + PTR_ONE;
      held_s     = count_r - CNT_ONE;
    end else begin
      rd_ptr_n_s = rd_ptr_r;
      held_s     = count_r;
    end
    case ({push_s, pop_s})
      2'b10:   count_n_s = count_r + CNT_ONE;
      2'b01:   count_n_s = count_r - CNT_ONE;
      default: count_n_s = count_r;
    endcase
  end

  // Storage array; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy and the registered head word.  Only words present
  // before the edge may become the head, so an empty FIFO never bypasses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {LW{1'b0}};
      valid_r  <= 1'b0;
      data_r   <= {WIDTH{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r <= rd_ptr_n_s;
      count_r  <= count_n_s;
      valid_r  <= (held_s != {LW{1'b0}});
      data_r   <= (held_s != {LW{1'b0}}) ? mem_r[rd_ptr_n_s] : {WIDTH{1'b0}};
    end
  end

  assign rd_valid = valid_r;
  assign rd_data  = data_r;
  assign full     = full_s;
  assign empty    = (count_r == {LW{1'b0}});
  assign level    = count_r;

endmodule

// File: rtl/fir_decim_stream.sv
// Block-average decimator behind the FIR filter: sums 2^shift samples, scales
// back by shift, and queues the results in a FWFT FIFO with an overflow flag.
module fir_decim_stream
  import fir_decim_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DSP_DATA_WIDTH,
  parameter int DEPTH      = 16,
  parameter int MAX_SHIFT  = DSP_MAX_SHIFT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [3:0]                    shift,
  input  logic signed [DATA_WIDTH-1:0]  x,
  output logic signed [DATA_WIDTH-1:0]  m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          overflow,
  input  logic                          clr_ovf
);

  localparam int ACC_W = DATA_WIDTH + MAX_SHIFT;
  localparam int CW    = MAX_SHIFT + 1;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic signed [ACC_W-1:0]      acc_r;
  logic signed [ACC_W-1:0]      x_ext_s;
  logic signed [ACC_W-1:0]      sum_s;
  logic signed [DATA_WIDTH-1:0] scaled_s;
  logic [CW-1:0]                cnt_r;
  logic [CW-1:0]                cnt_inc_s;
  logic [CW-1:0]                rate_s;
  logic [3:0]                   shift_lat_r;
  logic [3:0]                   eff_shift_s;
  logic                         first_s;
  logic                         last_s;
  logic signed [DATA_WIDTH-1:0] res_r;
  logic                         res_vld_r;
  logic                         overflow_r;
  logic                         drop_s;
  logic                         fifo_full_s;
  logic                         fifo_empty_s;
  logic [DATA_WIDTH-1:0]        fifo_rd_data_s;

  // Window arithmetic: the rate is fixed by the shift seen at the window's first sample.
  always_comb begin
    first_s = (cnt_r == {CW{1'b0}});
    if (first_s) begin
      eff_shift_s = clamp_shift(shift, MAX_SHIFT);
    end else begin
      eff_shift_s = shift_lat_r;
    end
    rate_s    = CNT_ONE << eff_shift_s;
    cnt_inc_s = cnt_r + CNT_ONE;
    last_s    = (cnt_inc_s == rate_s);
    x_ext_s   = {{MAX_SHIFT{x[DATA_WIDTH-1]}}, x};
    if (first_s) begin
      sum_s = x_ext_s;
    end else begin
      sum_s = acc_r + x_ext_s;
    end
    // The mean of R samples always fits DATA_WIDTH, so truncation is exact.
    scaled_s = DATA_WIDTH'(sum_s >>> eff_shift_s);
  end

  // Accumulate while enabled; dropping en abandons the partial window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r       <= {ACC_W{1'b0}};
      cnt_r       <= {CW{1'b0}};
      shift_lat_r <= 4'd0;
      res_r       <= {DATA_WIDTH{1'b0}};
      res_vld_r   <= 1'b0;
    end else if (en) begin
      shift_lat_r <= eff_shift_s;
      if (last_s) begin
        acc_r     <= {ACC_W{1'b0}};
        cnt_r     <= {CW{1'b0}};
        res_r     <= scaled_s;
        res_vld_r <= 1'b1;
      end else begin
        acc_r     <= sum_s;
        cnt_r     <= cnt_inc_s;
        res_vld_r <= 1'b0;
      end
    end else begin
      acc_r     <= {ACC_W{1'b0}};
      cnt_r     <= {CW{1'b0}};
      res_vld_r <= 1'b0;
    end
  end

  assign drop_s = res_vld_r & fifo_full_s & ~(m_tvalid & m_tready);

  // Sticky overflow; a drop on the clearing edge wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (clr_ovf) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (res_vld_r),
    .wr_data  (res_r),
    .rd_valid (m_tvalid),
    .rd_data  (fifo_rd_data_s),
    .rd_ready (m_tready),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .level    (level)
  );

  fir_decim_stream_chk #(
    .LW (LW)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .empty    (fifo_empty_s),
    .m_tvalid (m_tvalid),
    .level    (level)
  );

  assign m_tdata  = fifo_rd_data_s;
  assign overflow = overflow_r;

endmodule

// File: doc/fir_decim_stream.md
FIR_DECIM_STREAM -- requirements
Module: fir_decim_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of input sample and output word.
REQ-002 SHALL have parameter DEPTH, default 16, output FIFO depth in words, a power of 2 and at least 2.
REQ-003 SHALL have parameter MAX_SHIFT, default 10, largest supported log2 decimation factor.
REQ-004 SHALL have these ports:
  clk  in  1  system clock, rising edge.
  rst  in  1  reset, asynchronous, active-high.
  en  in  1  decimation enable.
  shift  in  4  log2 of decimation rate R; values above MAX_SHIFT are clamped to MAX_SHIFT.
  x  in  DATA_WIDTH signed  FIR filter output; one sample per clk.
  m_tdata  out  DATA_WIDTH signed  output word.
  m_tvalid  out  1  output word valid.
  m_tready  in  1  consumer ready.
  level  out  $clog2(DEPTH)+1  FIFO occupancy.
  overflow  out  1  sticky flag: a decimated word was dropped.
  clr_ovf  in  1  clears overflow.

Function
REQ-005 SHALL sample x on every rising clk while en=1; with en=0, x is ignored.
REQ-006 SHALL latch R=2^min(shift,MAX_SHIFT) at the first sample of each window; a shift change mid-window SHALL take effect at the next window only.
REQ-007 SHALL accumulate R consecutive samples in a signed accumulator DATA_WIDTH+MAX_SHIFT bits wide, with no overflow possible.
REQ-008 SHALL form the result as the accumulator arithmetically shifted right by the latched shift (truncation toward minus infinity); the result fits DATA_WIDTH and SHALL NOT be saturated.
REQ-009 SHALL restart the window with the next sample after the R-th sample, with no gap cycle; for R=1 every sample SHALL produce a result.
REQ-010 SHALL push the result into the FIFO on the clock edge after the edge that captured the R-th sample (one register stage).
REQ-011 SHALL assert m_tvalid on the edge following the push, for a total latency of 2 clk from the last sample to m_tvalid; the FIFO SHALL NOT bypass when empty.
REQ-012 SHALL present the FIFO head on m_tdata whenever m_tvalid=1 (first-word fall-through), holding m_tdata stable until the handshake.
REQ-013 SHALL pop one word on each edge where m_tvalid=1 and m_tready=1.
REQ-014 SHALL accept a push when the FIFO is full and a pop occurs on the same edge; level SHALL be unchanged.
REQ-015 SHALL drop the new word when the FIFO is full with no pop on that edge, and set overflow; FIFO contents SHALL be unchanged.
REQ-016 SHALL clear overflow on the edge where clr_ovf=1; if a drop occurs on the same edge, overflow SHALL stay set.
REQ-017 SHALL, when en falls mid-window, discard the partial window and clear the accumulator and sample counter; a result already registered SHALL still be pushed.
REQ-018 SHALL, when en rises, start a fresh window with the first sample captured.
REQ-019 SHALL keep draining the FIFO regardless of en.
REQ-020 SHALL make level equal to the number of words held, from 0 to DEPTH, updated on the same edge as the push or pop.

Reset
REQ-021 SHALL, on rst=1, immediately clear the accumulator, sample counter, result register, FIFO pointers, level, overflow and m_tvalid; m_tdata SHALL be 0.
REQ-022 SHALL lose all FIFO contents and any partial window on a reset asserted mid-operation.
REQ-023 SHALL capture the first sample on the first rising clk after rst deasserts, if en=1.

Structure
REQ-024 SHALL keep the default DATA_WIDTH and MAX_SHIFT and the shift-clamp function in the shared DSP package used by the FIR filter.
REQ-025 SHALL implement the FIFO as one sub-module, sync_fifo_fwft, parameterised by width and depth, exposing full, empty and level.

Verification
REQ-026 SHALL cover: shift=2, en=1, x=4,8,12,16 constant ready -> one word 10, m_tvalid rising 2 clk after x=16.
REQ-027 SHALL cover: shift=1, x=-3,-2 -> output -3 (floor of -2.5).
REQ-028 SHALL cover: shift=0, x=32767,-32768 -> outputs 32767,-32768 unchanged, one per clk.
REQ-029 SHALL cover: DEPTH=16, m_tready=0, 17 results -> level=16, overflow=1, first 16 words intact; m_tready=1 on full plus push edge -> level stays 16, no drop.
REQ-030 SHALL cover: shift 3 to 1 after the 2nd sample of a window -> that window averages 8 samples, the next averages 2; en low after 5 of 8 samples -> no word produced.
REQ-031 SHALL cover: rst pulse with level=5 and a half-filled window -> level=0, m_tvalid=0 and overflow=0 immediately; clr_ovf and a drop on the same edge -> overflow=1.
